processor_cpu_debug_scan_master: RTL and testbench
==================================================

Name: processor_cpu_debug_scan_master

Overview:
- Host-side initiator for the Nios II debug slave's virtual-JTAG interface.
- Takes one (IR, DR) scan command from a sysclk-domain agent (test sequencer / bridge). Generates the tck, tdi, ir_in and virtual-state strobe sequence the debug slave consumes, and returns the captured tdo word.
- Sits in place of the sld hub for simulation and for on-chip self-test of the debug slave.

Parameters:
- IR_WIDTH, 2, width of ir_in / cmd_ir.
- DR_WIDTH, 38, scan-chain length; equals the debug slave's sr/jdo width.
- TCK_DIV, 4, clk cycles per tck half-period; legal range >= 1.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle and accepting.
- cmd_ir  in  IR_WIDTH  instruction for this scan.
- cmd_data  in  DR_WIDTH  data shifted out on tdi, LSB first.
- rsp_valid  out  1  captured word available.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DR_WIDTH  captured tdo bits; first-captured bit lands at bit 0.
- tck  out  1  generated scan clock, registered, idles low.
- tdi  out  1  serial data to slave.
- tdo  in  1  serial data from slave.
- ir_in  out  IR_WIDTH  instruction register value.
- vs_uir, vs_cdr, vs_sdr, vs_udr  out  1 each  virtual state strobes.
- jtag_state_rti  out  1  run-test-idle indication.

Behaviour:
- Reset value of every output is 0, except cmd_ready, which is 1. While reset is asserted: state=IDLE, tck=0, shift register cleared.
- tck generation:
  - Divider counter runs only outside IDLE/RSP.
  - tck toggles every TCK_DIV clk cycles; one step = one tck period = 2*TCK_DIV clk cycles.
- Step boundary is the tck fall (1->0). ir_in, tdi and all vs_*/rti outputs update only on the clk edge that makes tck fall. The first step starts on the handshake edge, with tck held 0.
- tdo is sampled only on the clk edge that makes tck rise.
- Handshake:
  - Command accepted when cmd_valid && cmd_ready.
  - On that edge: ir_in<=cmd_ir, sr<=cmd_data, state<=UIR, cmd_ready<=0.
- FSM states and transitions (one step each unless noted):
  - IDLE -> UIR: vs_uir=1.
  - UIR -> CDR: vs_cdr=1.
  - CDR -> SDR: vs_sdr=1 for exactly DR_WIDTH steps. tdi=sr[0]. On each tck rise, sr<={tdo, sr[DR_WIDTH-1:1]}.
  - SDR -> UDR: vs_udr=1.
  - UDR -> RTI: jtag_state_rti=1.
  - RTI -> RSP.
- Strobes are mutually exclusive. All are 0 in IDLE and RSP. tdi is 0 outside SDR.
- Scan length: DR_WIDTH+4 steps. rsp_valid rises exactly (DR_WIDTH+4)*2*TCK_DIV clk cycles after the accept edge. rsp_data=sr.
- RSP: rsp_valid held, with rsp_data stable, until rsp_ready. On that edge: rsp_valid<=0, cmd_ready<=1, state<=IDLE. The next command can be accepted the following cycle; there is no command/response overlap.
- cmd_valid while busy: ignored, with no effect.
- ir_in holds its last value after the scan, until the next accept.
- Reset mid-operation aborts the scan immediately: no response is produced and all outputs return to reset values.
- TCK_DIV=1: tck toggles every clk cycle; all rules above are unchanged.
- Counters:
  - Bit counter: $clog2(DR_WIDTH+1) bits, counts down from DR_WIDTH-1.
  - Divider: $clog2(TCK_DIV+1) bits.
  - No wrap at the counters' maximum value is permitted.

Decomposition:
- Shared package processor_debug_pkg holds:
  - state enum {IDLE,UIR,CDR,SDR,UDR,RTI,RSP};
  - DEBUG_IR_WIDTH=2 and DEBUG_DR_WIDTH=38 constants;
  - IR codes (00 ocimem, 01 trace, 10 break, 11 trace-mem).
- One sub-module is natural: processor_cpu_debug_tck_gen. It holds the divider and emits tck plus one-cycle tck_rise and tck_fall enables.

Test Plan:
- Loopback (tdo=tdi), TCK_DIV=2, cmd_ir=2'b01, cmd_data=38'h2A_5A5A_5A5A -> rsp_data=38'h2A_5A5A_5A5A. ir_in=01 from accept onward. vs_sdr high exactly 38*4=152 clk cycles. rsp_valid exactly 168 cycles after accept.
- tdo tied 1, cmd_data=0 -> rsp_data=38'h3F_FFFF_FFFF. tdi=0 throughout SDR.
- Strobe order, TCK_DIV=1: vs_uir, vs_cdr, 38x vs_sdr, vs_udr, rti, each changing only on tck fall, never two high at once. Checked with DR_WIDTH=38 -> rsp after 84 cycles.
- Backpressure: rsp_ready=0 for 20 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, second cmd_valid ignored. rsp_ready=1 -> cmd_ready=1 next cycle.
- Reset asserted at SDR bit 17 -> all outputs 0 (cmd_ready=1) asynchronously, no rsp_valid. A new command after release completes normally.
- Back-to-back: two commands (ir 10 then 00) with rsp_ready=1 -> two correct responses, second accepted one cycle after first response handshake.

Source files
------------

// File: rtl/processor_cpu_debug_scan_master_pkg.sv
// processor_debug_pkg: shared scan states, debug-slave widths and IR codes.
package processor_debug_pkg;
  localparam int DEBUG_IR_WIDTH = 2;
  localparam int DEBUG_DR_WIDTH = 38;
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RSP} state_t;
  localparam logic [1:0] IR_OCIMEM = 2'b00;
  localparam logic [1:0] IR_TRACE = 2'b01;
  localparam logic [1:0] IR_BREAK = 2'b10;
  localparam logic [1:0] IR_TRACE_MEM = 2'b11;
endpackage

// File: rtl/processor_cpu_debug_scan_master_if.sv
// processor_cpu_debug_scan_master_if: command/response handshake plus virtual-JTAG pins.
// master = agent side (drives cmd_*, rsp_ready, tdo); slave = scan master side.
interface processor_cpu_debug_scan_master_if
  import processor_debug_pkg::*;
#(
  parameter int IR_WIDTH = DEBUG_IR_WIDTH,
  parameter int DR_WIDTH = DEBUG_DR_WIDTH
);
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [IR_WIDTH-1:0] cmd_ir, ir_in;
  logic [DR_WIDTH-1:0] cmd_data, rsp_data;
  logic tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready, tdo,
    input cmd_ready, rsp_valid, rsp_data, tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );
  modport slave (
    input cmd_valid, cmd_ir, cmd_data, rsp_ready, tdo,
    output cmd_ready, rsp_valid, rsp_data, tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );
endinterface

// File: rtl/processor_cpu_debug_tck_gen.sv
// processor_cpu_debug_tck_gen: tck divider with one-cycle rise/fall enables.
// Ports: clk, reset (async), i_run enables the divider; o_tck, o_rise, o_fall.
module processor_cpu_debug_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  output logic o_tck,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(TCK_DIV + 1);
  logic [CW-1:0] r_cnt;
  logic r_tck, w_wrap;
  assign w_wrap = i_run && r_cnt == CW'(TCK_DIV - 1);
  assign o_rise = w_wrap && !r_tck;
  assign o_fall = w_wrap && r_tck;
  assign o_tck = r_tck;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (!i_run) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      r_tck <= r_tck ^ w_wrap;
    end
  end
endmodule

// File: rtl/processor_cpu_debug_scan_master.sv
// processor_cpu_debug_scan_master: drives one IR/DR virtual-JTAG scan into the debug slave.
// Ports: clk, reset (async, active high), bus (slave modport: cmd/rsp handshake, tck/tdi/tdo, ir_in, vs_* strobes).
module processor_cpu_debug_scan_master
  import processor_debug_pkg::*;
#(
  parameter int IR_WIDTH = DEBUG_IR_WIDTH,
  parameter int DR_WIDTH = DEBUG_DR_WIDTH,
  parameter int TCK_DIV = 4
) (
  input logic clk,
  input logic reset,
  processor_cpu_debug_scan_master_if.slave bus
);
  localparam int BW = $clog2(DR_WIDTH + 1);
  state_t r_state, w_next;
  logic [DR_WIDTH-1:0] r_sr;
  logic [BW-1:0] r_bit;
  logic [IR_WIDTH-1:0] r_ir;
  logic r_tdi, w_run, w_tck, w_rise, w_fall;
  assign w_run = r_state != IDLE && r_state != RSP;
  processor_cpu_debug_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk(clk), .reset(reset), .i_run(w_run), .o_tck(w_tck), .o_rise(w_rise), .o_fall(w_fall)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = bus.cmd_valid ? UIR : IDLE;
      UIR: w_next = w_fall ? CDR : UIR;
      CDR: w_next = w_fall ? SDR : CDR;
      SDR: w_next = (w_fall && r_bit == '0) ? UDR : SDR;
      UDR: w_next = w_fall ? RTI : UDR;
      RTI: w_next = w_fall ? RSP : RTI;
      RSP: w_next = bus.rsp_ready ? IDLE : RSP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr <= '0;
      r_bit <= '0;
      r_ir <= '0;
      r_tdi <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.cmd_valid) begin
        r_ir <= bus.cmd_ir;
        r_sr <= bus.cmd_data;
      end else if (r_state == SDR && w_rise) begin
        r_sr <= {bus.tdo, r_sr[DR_WIDTH-1:1]};
      end
      if (w_fall) begin
        // rise and fall never share an edge, so r_sr here already holds the last shift
        r_bit <= r_state == CDR ? BW'(DR_WIDTH - 1) : (r_state == SDR && r_bit != '0) ? r_bit - BW'(1) : r_bit;
        r_tdi <= w_next == SDR ? r_sr[0] : 1'b0;
      end
    end
  end
  assign bus.cmd_ready = r_state == IDLE;
  assign bus.rsp_valid = r_state == RSP;
  assign bus.rsp_data = r_sr;
  assign bus.tck = w_tck;
  assign bus.tdi = r_tdi;
  assign bus.ir_in = r_ir;
  assign bus.vs_uir = r_state == UIR;
  assign bus.vs_cdr = r_state == CDR;
  assign bus.vs_sdr = r_state == SDR;
  assign bus.vs_udr = r_state == UDR;
  assign bus.jtag_state_rti = r_state == RTI;
endmodule

// File: tb/tb_processor_cpu_debug_scan_master.sv
// tb_processor_cpu_debug_scan_master: randomized scans on TCK_DIV=2 and TCK_DIV=1 instances against a step-level model.
module tb_processor_cpu_debug_scan_master;
  import processor_debug_pkg::*;
  localparam int DR = DEBUG_DR_WIDTH;
  localparam int IRW = DEBUG_IR_WIDTH;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic sel = 1'b0, cv = 1'b0, rr = 1'b0, loop = 1'b0, tdo_drv = 1'b0;
  logic [IRW-1:0] c_ir = '0;
  logic [DR-1:0] c_data = '0;
  processor_cpu_debug_scan_master_if #(.IR_WIDTH(IRW), .DR_WIDTH(DR)) ifa ();
  processor_cpu_debug_scan_master_if #(.IR_WIDTH(IRW), .DR_WIDTH(DR)) ifb ();
  processor_cpu_debug_scan_master #(.IR_WIDTH(IRW), .DR_WIDTH(DR), .TCK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  processor_cpu_debug_scan_master #(.IR_WIDTH(IRW), .DR_WIDTH(DR), .TCK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );
  assign ifa.cmd_valid = cv && !sel;
  assign ifb.cmd_valid = cv && sel;
  assign ifa.cmd_ir = c_ir;
  assign ifb.cmd_ir = c_ir;
  assign ifa.cmd_data = c_data;
  assign ifb.cmd_data = c_data;
  assign ifa.rsp_ready = rr && !sel;
  assign ifb.rsp_ready = rr && sel;
  assign ifa.tdo = loop ? ifa.tdi : tdo_drv;
  assign ifb.tdo = loop ? ifb.tdi : tdo_drv;
  logic obs_ready, obs_valid, obs_tck, obs_tdi;
  logic [DR-1:0] obs_data;
  logic [IRW-1:0] obs_ir;
  logic [4:0] obs_strb;
  assign obs_ready = sel ? ifb.cmd_ready : ifa.cmd_ready;
  assign obs_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
  assign obs_tck = sel ? ifb.tck : ifa.tck;
  assign obs_tdi = sel ? ifb.tdi : ifa.tdi;
  assign obs_data = sel ? ifb.rsp_data : ifa.rsp_data;
  assign obs_ir = sel ? ifb.ir_in : ifa.ir_in;
  assign obs_strb = sel ? {ifb.vs_uir, ifb.vs_cdr, ifb.vs_sdr, ifb.vs_udr, ifb.jtag_state_rti}
                        : {ifa.vs_uir, ifa.vs_cdr, ifa.vs_sdr, ifa.vs_udr, ifa.jtag_state_rti};
  int vecs = 0, errs = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DR-1:0] rnd_dr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DR-1:0];
  endfunction
  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(obs_ready), 64'd1);
    check({tag, "_valid"}, 64'(obs_valid), 64'd0);
    check({tag, "_tck"}, 64'(obs_tck), 64'd0);
    check({tag, "_tdi"}, 64'(obs_tdi), 64'd0);
    check({tag, "_strb"}, 64'(obs_strb), 64'd0);
    check({tag, "_ir"}, 64'(obs_ir), 64'd0);
    check({tag, "_data"}, 64'(obs_data), 64'd0);
  endtask
  // Call at a falling clk edge; returns at the falling edge after the response handshake (or after an abort).
  task automatic scan(input logic s, input logic [IRW-1:0] ir, input logic [DR-1:0] data, input logic lb,
                      input logic [DR-1:0] pat, input int bp, input int abort_at);
    int div, n, rises, sdr_cyc, bad_oh, bad_edge, bad_tdi, bad_ir, nseq, bad;
    logic [DR-1:0] tdi_seen, exp_rsp, held;
    logic [4:0] prev_strb;
    logic prev_tck;
    logic [24:0] seq;
    div = s ? 1 : 2;
    sel = s; loop = lb; c_ir = ir; c_data = data; tdo_drv = pat[0];
    exp_rsp = lb ? data : pat;
    n = 0; rises = 0; sdr_cyc = 0; bad_oh = 0; bad_edge = 0; bad_tdi = 0; bad_ir = 0; nseq = 0; bad = 0;
    tdi_seen = '0; seq = '0; prev_strb = '0; prev_tck = 1'b0;
    #1;
    check("ready_before_cmd", 64'(obs_ready), 64'd1);
    cv = 1'b1;
    @(negedge clk);
    cv = 1'b0;
    while (!obs_valid && n < 4000) begin
      if ($countones(obs_strb) > 1) bad_oh++;
      if (obs_strb != prev_strb) begin
        if (n != 0 && !(prev_tck && !obs_tck)) bad_edge++;
        if (nseq < 5) seq[24 - 5 * nseq -: 5] = obs_strb;
        nseq++;
      end
      if (obs_strb[2]) sdr_cyc++;
      if (!obs_strb[2] && obs_tdi) bad_tdi++;
      if (obs_ir != ir) bad_ir++;
      if (obs_strb[2] && !prev_tck && obs_tck) begin
        if (rises < DR) tdi_seen[rises] = obs_tdi;
        rises++;
        if (rises < DR) tdo_drv = pat[rises];
      end
      if (rises == abort_at) begin
        #1 reset = 1'b1;
        #1 check_idle_outputs("abort");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (obs_valid || !obs_ready) bad++;
        end
        check("abort_no_rsp", 64'(bad), 64'd0);
        return;
      end
      prev_strb = obs_strb;
      prev_tck = obs_tck;
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(2 * div * (DR + 4)));
    check("sdr_cycles", 64'(sdr_cyc), 64'(2 * div * DR));
    check("sdr_bits", 64'(rises), 64'(DR));
    check("tdi_stream", 64'(tdi_seen), 64'(data));
    check("strobe_onehot", 64'(bad_oh), 64'd0);
    check("strobe_on_fall", 64'(bad_edge), 64'd0);
    check("tdi_outside_sdr", 64'(bad_tdi), 64'd0);
    check("ir_in_held", 64'(bad_ir), 64'd0);
    check("strobe_seq", 64'(seq), 64'({5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001}));
    check("strobe_steps", 64'(nseq), 64'd5);
    check("rsp_data", 64'(obs_data), 64'(exp_rsp));
    check("rsp_quiet", 64'({obs_strb, obs_tck, obs_tdi, obs_ready}), 64'd0);
    held = obs_data;
    for (int i = 0; i < bp; i++) begin
      if (i == 5) begin
        c_ir = ~ir;
        cv = 1'b1;
      end
      @(negedge clk);
      cv = 1'b0;
      if (!obs_valid || obs_data !== held || obs_ready) bad++;
    end
    if (bp > 0) check("backpressure_hold", 64'(bad), 64'd0);
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    check("ready_after_rsp", 64'(obs_ready), 64'd1);
    check("valid_after_rsp", 64'(obs_valid), 64'd0);
    check("ir_after_rsp", 64'(obs_ir), 64'(ir));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    scan(1'b0, 2'b01, 38'h2A_5A5A_5A5A, 1'b1, '0, 0, -1);
    scan(1'b0, IRW'($urandom), '0, 1'b0, '1, 0, -1);
    scan(1'b1, 2'b11, rnd_dr(), 1'b1, '0, 0, -1);
    scan(1'b0, 2'b01, rnd_dr(), 1'b0, rnd_dr(), 20, -1);
    scan(1'b0, 2'b11, rnd_dr(), 1'b1, '0, 0, 17);
    scan(1'b0, 2'b10, rnd_dr(), 1'b0, rnd_dr(), 0, -1);
    scan(1'b0, IR_BREAK, rnd_dr(), 1'b1, '0, 0, -1);
    scan(1'b0, IR_OCIMEM, rnd_dr(), 1'b0, rnd_dr(), 0, -1);
    for (int k = 0; k < 6; k++)
      scan(1'($urandom_range(0, 1)), IRW'($urandom), rnd_dr(), 1'($urandom_range(0, 1)), rnd_dr(),
           int'($urandom_range(0, 3)), -1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
